mynand_3: RTL and testbench

MYNAND_3 -- requirements
Module: mynand_3

---
 rtl/mynand_pkg.sv | 34 +++
 rtl/mynand_3_not.sv | 17 +
 rtl/mynand_3.sv | 112 +++++++++++
 tb/tb_mynand_3.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mynand_pkg.sv
// ---------------------------------------------------------------------------
// mynand_pkg
// Shared constants and types for the delayed three-input NAND cell
// (mynand_3) and its helper inverter (mynot).
//
// Contents:
//   CNT_W    width of the pending-transition counter
//   MAX_DLY  largest delay, in clock cycles, the counter can represent
//   Y_RST    value of y after reset (NAND of idle-low inputs)
//   cnt_t    counter type
//   dir_e    direction of a pending output transition
//   dly_ok   true when a delay parameter lies inside 1..MAX_DLY
// ---------------------------------------------------------------------------
package mynand_pkg;

   localparam int   CNT_W   = 4;
   localparam int   MAX_DLY = 15;
   localparam logic Y_RST   = 1'b1;

   typedef logic [CNT_W-1:0] cnt_t;

   // A rise is driven by a single PMOS, a fall by the three-NMOS stack,
   // so the direction alone selects which delay applies.
   typedef enum logic {
      DIR_FALL = 1'b0,
      DIR_RISE = 1'b1
   } dir_e;

   // Used at elaboration to reject delay parameters the counter cannot hold.
   function automatic bit dly_ok(input int dly);
      return (dly >= 1) && (dly <= MAX_DLY);
   endfunction

endpackage

// File: rtl/mynand_3_not.sv
// ---------------------------------------------------------------------------
// mynot
// Purely combinational inverter. No clock, no reset.
// Used by mynand_3 to derive y_bar from the registered output.
//
// Ports:
//   a  input   1  value to invert
//   y  output  1  NOT a
// ---------------------------------------------------------------------------
module mynot (
   input  logic a,
   output logic y
);

   assign y = ~a;

endmodule

// File: rtl/mynand_3.sv
// ---------------------------------------------------------------------------
// mynand_3
// Clocked model of a three-input NAND gate with separate rise and fall
// delays and inertial filtering. The output only follows the NAND of the
// inputs once the new value has been seen on D consecutive rising edges,
// where D is RISE_DLY for a 0->1 transition and FALL_DLY for 1->0. Shorter
// pulses are swallowed.
//
// Parameters:
//   RISE_DLY  cycles for y 0->1, legal range 1..15 (default 2)
//   FALL_DLY  cycles for y 1->0, legal range 1..15 (default 4)
//
// Ports:
//   clk    input   1  sole clock, rising edge
//   rst    input   1  synchronous, active-high reset (y <= 1, counter <= 0)
//   a      input   1  NAND input 1
//   b      input   1  NAND input 2
//   c      input   1  NAND input 3
//   y      output  1  registered, delayed NAND result
//   y_bar  output  1  NOT y, present only when MYNAND_3_YBAR_EN is defined
//
// Configuration macro:
//   MYNAND_3_YBAR_EN  adds the y_bar port and one mynot instance driving it
// ---------------------------------------------------------------------------
module mynand_3
   import mynand_pkg::*;
#(
   parameter int RISE_DLY = 2,
   parameter int FALL_DLY = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
`ifdef MYNAND_3_YBAR_EN
   ,
   output logic y_bar
`endif
);

   // Delays are compared against counter+1, which can reach MAX_DLY+1,
   // so the comparison is done one bit wider than the counter itself.
   localparam logic [CNT_W:0] RISE_D  = (CNT_W+1)'(RISE_DLY);
   localparam logic [CNT_W:0] FALL_D  = (CNT_W+1)'(FALL_DLY);
   localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);

   // Reject delays the 4-bit counter cannot represent (and zero, which
   // would mean a transition faster than a plain register).
   if (!dly_ok(RISE_DLY)) begin : g_bad_rise_dly
      $error("mynand_3: RISE_DLY=%0d outside legal range 1..%0d", RISE_DLY, MAX_DLY);
   end
   if (!dly_ok(FALL_DLY)) begin : g_bad_fall_dly
      $error("mynand_3: FALL_DLY=%0d outside legal range 1..%0d", FALL_DLY, MAX_DLY);
   end

   logic             n;
   dir_e             dir;
   logic [CNT_W:0]   dly_sel;
   logic [CNT_W:0]   cnt_inc;
   cnt_t             cnt_q;
   cnt_t             cnt_d;
   logic             y_q;
   logic             y_d;

   // Next-state logic. When the target agrees with the output any pending
   // transition is cancelled by clearing the counter, which is what gives
   // the inertial behaviour: a reversal mid-count always restarts from zero.
   // When they differ, the counter advances until it has seen the target on
   // D consecutive edges, at which point the output commits to the target.
   always_comb begin
      n       = ~(a & b & c);
      dir     = n ? DIR_RISE : DIR_FALL;
      dly_sel = (dir == DIR_RISE) ? RISE_D : FALL_D;
      cnt_inc = {1'b0, cnt_q} + CNT_ONE;
      y_d     = y_q;
      cnt_d   = '0;
      if (n != y_q) begin
         if (cnt_inc >= dly_sel) begin
            y_d   = n;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
         end
      end
   end

   // State register. Reset overrides any pending transition and returns the
   // cell to the NAND of idle-low inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q   <= Y_RST;
         cnt_q <= '0;
      end else begin
         y_q   <= y_d;
         cnt_q <= cnt_d;
      end
   end

   assign y = y_q;

`ifdef MYNAND_3_YBAR_EN
   // y_bar is taken from the registered output, so it carries no
   // combinational path from a/b/c either.
   mynot u_ybar_not (
      .a (y_q),
      .y (y_bar)
   );
`endif

endmodule

// File: tb/tb_mynand_3.sv
// ---------------------------------------------------------------------------
// tb_mynand_3
// Directed, self-checking bench for mynand_3 and mynot.
//   dut      : default delays (RISE_DLY=2, FALL_DLY=4)
//   dut_d1   : RISE_DLY=FALL_DLY=1, behaves as a plain registered NAND
//   u_not    : standalone mynot
// When MYNAND_3_YBAR_EN is defined, y_bar of both cells is checked too.
// ---------------------------------------------------------------------------
module tb_mynand_3;

   logic clk;
   logic rst;
   logic a, b, c, y;
   logic a1, b1, c1, y1;
   logic na, ny;
`ifdef MYNAND_3_YBAR_EN
   logic y_bar;
   logic y1_bar;
`endif

   int checks;
   int errors;

   logic [7:0] nand_tbl;
   logic [2:0] vec;

   mynand_3 #(.RISE_DLY(2), .FALL_DLY(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .c     (c),
      .y     (y)
`ifdef MYNAND_3_YBAR_EN
      ,
      .y_bar (y_bar)
`endif
   );

   mynand_3 #(.RISE_DLY(1), .FALL_DLY(1)) dut_d1 (
      .clk   (clk),
      .rst   (rst),
      .a     (a1),
      .b     (b1),
      .c     (c1),
      .y     (y1)
`ifdef MYNAND_3_YBAR_EN
      ,
      .y_bar (y1_bar)
`endif
   );

   mynot u_not (
      .a (na),
      .y (ny)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ia, input logic ib, input logic ic,
                                input logic ir);
      a   = ia;
      b   = ib;
      c   = ic;
      rst = ir;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] obs,
                              input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // y of the default-delay cell, plus y_bar when it exists.
   task automatic checkY(input string tag, input logic exp);
      checkOutput(tag, {3'b000, y}, {3'b000, exp});
`ifdef MYNAND_3_YBAR_EN
      checkOutput({tag, "_ybar"}, {3'b000, y_bar}, {3'b000, ~exp});
`endif
   endtask

   task automatic checkY1(input string tag, input logic exp);
      checkOutput(tag, {3'b000, y1}, {3'b000, exp});
`ifdef MYNAND_3_YBAR_EN
      checkOutput({tag, "_ybar"}, {3'b000, y1_bar}, {3'b000, ~exp});
`endif
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      nand_tbl = 8'b0111_1111;
      na       = 1'b0;
      a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Reset state.
      tick();
      checkY("reset_y", 1'b1);
      checkOutput("reset_cnt", dut.cnt_q, 4'd0);
      checkY1("reset_y1", 1'b1);

      // Fall: all ones from edge 0, y drops at edge 3.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      tick(); checkY("fall_e0", 1'b1);
      checkOutput("fall_cnt_e0", dut.cnt_q, 4'd1);
      tick(); checkY("fall_e1", 1'b1);
      tick(); checkY("fall_e2", 1'b1);
      checkOutput("fall_cnt_e2", dut.cnt_q, 4'd3);
      tick(); checkY("fall_e3", 1'b0);
      checkOutput("fall_cnt_e3", dut.cnt_q, 4'd0);

      // Rise after two edges, then fall again after four.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      tick(); checkY("rise_k", 1'b0);
      tick(); checkY("rise_k1", 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      tick(); checkY("refall_e0", 1'b1);
      tick(); checkY("refall_e1", 1'b1);
      tick(); checkY("refall_e2", 1'b1);
      tick(); checkY("refall_e3", 1'b0);

      // Reversal mid-count restarts the rise counter.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      tick(); checkY("rev_e0", 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      tick(); checkY("rev_back", 1'b0);
      checkOutput("rev_cnt_clr", dut.cnt_q, 4'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      tick(); checkY("rev_restart0", 1'b0);
      checkOutput("rev_cnt1", dut.cnt_q, 4'd1);
      tick(); checkY("rev_restart1", 1'b1);

      // Two-edge pulse shorter than FALL_DLY is swallowed.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      tick(); checkY("pulse_e0", 1'b1);
      tick(); checkY("pulse_e1", 1'b1);
      checkOutput("pulse_cnt2", dut.cnt_q, 4'd2);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      tick(); checkY("pulse_end", 1'b1);
      checkOutput("pulse_cnt_clr", dut.cnt_q, 4'd0);
      tick(); checkY("pulse_after", 1'b1);

      // Reset at edge 2 of a pending fall, then the fall restarts.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      tick(); tick();
      checkOutput("rstmid_cnt2", dut.cnt_q, 4'd2);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      tick(); checkY("rstmid_y", 1'b1);
      checkOutput("rstmid_cnt", dut.cnt_q, 4'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      tick(); checkY("rstmid_e0", 1'b1);
      tick(); checkY("rstmid_e1", 1'b1);
      tick(); checkY("rstmid_e2", 1'b1);
      tick(); checkY("rstmid_e3", 1'b0);

      // Unit delays: plain registered NAND over all combinations.
      for (int i = 0; i < 8; i++) begin
         vec = 3'(i);
         a1 = vec[2]; b1 = vec[1]; c1 = vec[0];
         tick();
         checkY1($sformatf("d1_up_%0d", i), nand_tbl[i]);
      end
      // No combinational path: an input change alone leaves y1 alone.
      a1 = 1'b0;
      #1;
      checkY1("d1_nocomb", 1'b0);
      for (int i = 7; i >= 0; i--) begin
         vec = 3'(i);
         a1 = vec[2]; b1 = vec[1]; c1 = vec[0];
         tick();
         checkY1($sformatf("d1_dn_%0d", i), nand_tbl[i]);
      end

      // Standalone inverter.
      na = 1'b0;
      #1;
      checkOutput("not_a0", {3'b000, ny}, 4'd1);
      na = 1'b1;
      #1;
      checkOutput("not_a1", {3'b000, ny}, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
